// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Used by fetch_stage and if_id_reg; FETCH_PERF_CNT_EN builds use sat_inc32.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned FETCH_ADDR_W  = 32;
    localparam int unsigned FETCH_INSTR_W = 32;

    localparam logic [FETCH_INSTR_W-1:0] DEFAULT_NOP_INSTR = '0;
    localparam logic [FETCH_ADDR_W-1:0]  DEFAULT_RESET_PC  = '0;

    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
        logic                     valid;
    } if_id_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush loads a bubble, load captures a fetched word,
// otherwise the contents hold. Asynchronous active-low reset.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int unsigned           ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned           INSTR_W   = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0]     RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [INSTR_W-1:0]    NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic [ADDR_W-1:0]  pc_i,
    output logic [INSTR_W-1:0] instr_o,
    output logic [ADDR_W-1:0]  pc_o,
    output logic               valid_o
);

    logic [INSTR_W-1:0] instr_d, instr_q;
    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic               valid_d, valid_q;

    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            pc_d    = pc_i;
            valid_d = 1'b0;
        end else if (load_i) begin
            instr_d = instr_i;
            pc_d    = pc_i;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, BOOT/RUN/HALT FSM.
// Define FETCH_PERF_CNT_EN to add saturating fetched/bubble performance counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W    = FETCH_ADDR_W,
    parameter int unsigned        INSTR_W   = FETCH_INSTR_W,
    parameter logic [ADDR_W-1:0]  RESET_PC  = ADDR_W'(DEFAULT_RESET_PC),
    parameter logic [ADDR_W-1:0]  PC_INC    = ADDR_W'(1),
    parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEFAULT_NOP_INSTR)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [ADDR_W-1:0]  imem_addr_o,
    input  logic [INSTR_W-1:0] imem_instr_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [ADDR_W-1:0]  redirect_pc_i,
    input  logic               halt_i,
    output logic [INSTR_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0]  if_id_pc_o,
    output logic               if_id_valid_o,
    output logic               halted_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetched_o,
    output logic [31:0]        perf_bubbles_o
`endif
);

    fetch_state_e       state_d, state_q;
    logic [ADDR_W-1:0]  pc_d, pc_q;
    logic               halted_d, halted_q;
    logic               load;
    logic               flush;

    // Redirect beats halt beats stall; HALT ignores stall and only leaves on redirect.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        load    = 1'b0;
        flush   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                flush   = 1'b1;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    pc_d  = redirect_pc_i;
                    flush = 1'b1;
                end else if (halt_i) begin
                    state_d = ST_HALT;
                    flush   = 1'b1;
                end else if (!stall_i) begin
                    pc_d = pc_q + PC_INC;
                    load = 1'b1;
                end
            end
            ST_HALT: begin
                flush = 1'b1;
                if (redirect_i) begin
                    pc_d    = redirect_pc_i;
                    state_d = ST_RUN;
                end
            end
            default: begin
                flush   = 1'b1;
                state_d = ST_BOOT;
            end
        endcase
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_BOOT;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
        end
    end

    assign imem_addr_o = pc_q;
    assign halted_o    = halted_q;

    if_id_reg #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .flush_i(flush),
        .instr_i(imem_instr_i),
        .pc_i   (pc_q),
        .instr_o(if_id_instr_o),
        .pc_o   (if_id_pc_o),
        .valid_o(if_id_valid_o)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetched_d, fetched_q;
    logic [31:0] bubbles_d, bubbles_q;

    // Outside BOOT every non-loading edge is either a bubble or a stall hold.
    always_comb begin
        fetched_d = fetched_q;
        bubbles_d = bubbles_q;
        if (load) begin
            fetched_d = sat_inc32(fetched_q);
        end else if (state_q != ST_BOOT) begin
            bubbles_d = sat_inc32(bubbles_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_q <= '0;
            bubbles_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            bubbles_q <= bubbles_d;
        end
    end

    assign perf_fetched_o = fetched_q;
    assign perf_bubbles_o = bubbles_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a combinational instruction memory model.
// Perf-counter checks are compiled in when FETCH_PERF_CNT_EN is defined.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Words 0..3 are 0x11..0x44, other low words 0x1000+addr, high addresses addr^0xA5A50000.
    always_comb begin
        if (imem_addr < 32'd4)
            imem_instr = 32'h11 * (imem_addr + 32'd1);
        else if (imem_addr < 32'd256)
            imem_instr = 32'h1000 + imem_addr;
        else
            imem_instr = imem_addr ^ 32'hA5A5_0000;
    end

    fetch_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_addr_o  (imem_addr),
        .imem_instr_i (imem_instr),
        .stall_i      (stall),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halt_i       (halt),
        .if_id_instr_o(if_id_instr),
        .if_id_pc_o   (if_id_pc),
        .if_id_valid_o(if_id_valid),
        .halted_o     (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetched_o(perf_fetched),
        .perf_bubbles_o(perf_bubbles)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_instr, input logic [31:0] e_pc,
                           input logic e_valid, input logic [31:0] e_addr, input logic e_halted);
        chk({tag, ".instr"},  if_id_instr, e_instr);
        chk({tag, ".pc"},     if_id_pc, e_pc);
        chk({tag, ".valid"},  {31'b0, if_id_valid}, {31'b0, e_valid});
        chk({tag, ".addr"},   imem_addr, e_addr);
        chk({tag, ".halted"}, {31'b0, halted}, {31'b0, e_halted});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        #2;
        chk_all("reset", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step(); chk_all("boot", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        step(); chk_all("fetch0", 32'h11, 32'h0, 1'b1, 32'h1, 1'b0);
        step(); chk_all("fetch1", 32'h22, 32'h1, 1'b1, 32'h2, 1'b0);

        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); chk_all("stall_hold", 32'h22, 32'h1, 1'b1, 32'h2, 1'b0);
        end
        stall = 1'b0;
        step(); chk_all("stall_release", 32'h33, 32'h2, 1'b1, 32'h3, 1'b0);
        step(); chk_all("fetch3", 32'h44, 32'h3, 1'b1, 32'h4, 1'b0);
        step(); chk_all("fetch4", 32'h1004, 32'h4, 1'b1, 32'h5, 1'b0);

        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        step(); chk_all("redir_bubble", 32'h0, 32'h5, 1'b0, 32'h40, 1'b0);
        redirect = 1'b0; stall = 1'b0;
        step(); chk_all("redir_target", 32'h1040, 32'h40, 1'b1, 32'h41, 1'b0);

        halt = 1'b1;
        step(); chk_all("halt_enter", 32'h0, 32'h41, 1'b0, 32'h41, 1'b1);
        halt = 1'b0; stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(); chk_all("halt_stay", 32'h0, 32'h41, 1'b0, 32'h41, 1'b1);
        end
        stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h0;
        step(); chk_all("halt_exit", 32'h0, 32'h41, 1'b0, 32'h0, 1'b0);
        redirect = 1'b0;
        step(); chk_all("resume0", 32'h11, 32'h0, 1'b1, 32'h1, 1'b0);

        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(); chk_all("wrap_redir", 32'h0, 32'h1, 1'b0, 32'hFFFF_FFFF, 1'b0);
        redirect = 1'b0;
        step(); chk_all("wrap_top", 32'h5A5A_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0);
        step(); chk_all("wrap_zero", 32'h11, 32'h0, 1'b1, 32'h1, 1'b0);

        // Fresh run from reset: 5 fetches, 2 stall edges, 5 fetches, 1 redirect edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("rst_again", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();
        for (int i = 0; i < 5; i++) step();
        chk_all("perf_run_a", 32'h1004, 32'h4, 1'b1, 32'h5, 1'b0);
        stall = 1'b1;
        step(); step();
        stall = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk_all("perf_run_b", 32'h1009, 32'h9, 1'b1, 32'hA, 1'b0);
        redirect = 1'b1; redirect_pc = 32'h20;
        step();
        redirect = 1'b0;
        chk_all("perf_redir", 32'h0, 32'hA, 1'b0, 32'h20, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, 32'd10);
        chk("perf_bubbles", perf_bubbles, 32'd3);
`endif

        // Asynchronous reset in the middle of a cycle.
        #3;
        rst_n = 1'b0;
        #1;
        chk_all("rst_mid", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef FETCH_PERF_CNT_EN
        chk("rst_mid.fetched", perf_fetched, 32'd0);
        chk("rst_mid.bubbles", perf_bubbles, 32'd0);
`endif
        step();
        chk_all("rst_held", 32'h0, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined processor. Owns the program counter and drives the combinational instruction memory's address. Captures the returned word into the IF/ID pipeline register for decode. Handles hazard-unit stalls, branch/jump redirects with flush, and a halt state.

## Interface
- `ADDR_W`, default 32: PC and memory address width.
- `INSTR_W`, default 32: instruction width.
- `RESET_PC`, default 0: PC value after reset.
- `PC_INC`, default 1: PC increment. The instruction memory is word-indexed, so the default steps one word per instruction.
- `NOP_INSTR`, default all-zero: encoding inserted on bubbles and flushes.

- `clk`, in, 1: single clock. All state changes on the rising edge.
- `rst_n`, in, 1: reset. Asynchronous assert, active-low.
- `imem_addr_o`, out, ADDR_W: address to the instruction memory. Equals the PC register.
- `imem_instr_i`, in, INSTR_W: combinational read data from the instruction memory.
- `stall_i`, in, 1: hazard unit requests hold of PC and IF/ID.
- `redirect_i`, in, 1: taken branch or jump resolved downstream.
- `redirect_pc_i`, in, ADDR_W: target address for the redirect.
- `halt_i`, in, 1: decode detected a halt instruction.
- `if_id_instr_o`, out, INSTR_W: registered instruction.
- `if_id_pc_o`, out, ADDR_W: PC of `if_id_instr_o`.
- `if_id_valid_o`, out, 1: IF/ID holds a real instruction.
- `halted_o`, out, 1: fetch is in the HALT state.

## Operation
- Three-state FSM: BOOT, RUN, HALT.
  - BOOT: the first cycle after reset release. PC is held at RESET_PC and IF/ID loads a bubble. This gives the memory a full cycle to settle. Next state is RUN.
  - RUN: normal fetch.
  - HALT: PC frozen and IF/ID loads bubbles every cycle. Only `redirect_i` exits HALT (to RUN). `stall_i` is ignored in HALT.
- Per-edge priority in RUN, highest first:
  1. redirect: PC <= `redirect_pc_i`; IF/ID <= bubble (flush).
  2. halt_i: next state is HALT; PC holds; IF/ID <= bubble.
  3. stall_i: PC and all IF/ID fields hold their values.
  4. Normal: PC <= PC + PC_INC; IF/ID <= {`imem_instr_i`, PC, valid=1}.
- Bubble definition: instr=NOP_INSTR, pc=current PC, valid=0.
- Arithmetic: PC addition is modulo 2^ADDR_W. The all-ones PC wraps to 0 without any flag.
- `redirect_pc_i` is taken as-is, with no alignment check.
- `redirect_i` and `stall_i` together: the redirect wins and the stalled IF/ID content is discarded.

## Timing
- Reset values: PC=RESET_PC, state=BOOT, `imem_addr_o`=RESET_PC, `if_id_instr_o`=NOP_INSTR, `if_id_pc_o`=RESET_PC, `if_id_valid_o`=0, `halted_o`=0. Counters (when enabled) are 0.
- `imem_addr_o` is a direct flop output, with no combinational path from any input. `imem_instr_i` must be stable within the same cycle. This budget covers the memory's 1 ns output delay.
- Fetch latency: an instruction at address A appears on IF/ID one edge after `imem_addr_o`=A.
- First valid IF/ID arrives on the second edge after `rst_n` rises.
- Redirect penalty: `redirect_i` sampled at edge N sets IF/ID invalid at N. The target instruction appears valid at edge N+1, giving exactly one bubble cycle.
- Stall: a stall sampled at edge N freezes the outputs across N. Fetch resumes on the first edge with `stall_i`=0.
- Reset mid-operation: all state returns to reset values immediately, without waiting for a clock. The in-flight IF/ID content is lost.

## Configuration
- Macro: `FETCH_PERF_CNT_EN`.
- Defined: adds two outputs, each saturating at all-ones and reset to 0.
  - `perf_fetched_o` (32 bits): counts edges that load IF/ID with valid=1.
  - `perf_bubbles_o` (32 bits): counts edges in RUN or HALT that load a bubble, plus edges held by stall.
- Undefined: neither port nor counter exists. All other behaviour is identical.

## Structure
- Shared package `fetch_pkg` holds:
  - the FSM state enum (BOOT/RUN/HALT);
  - the `if_id_t` struct {instr, pc, valid};
  - the default NOP_INSTR and RESET_PC constants.
- One sub-module, `if_id_reg`: the IF/ID register with load, hold and flush controls plus asynchronous active-low reset.
- The PC, next-PC priority mux, FSM and optional counters live in `fetch_stage`.

## Test plan
- Reset release with memory words 0..3 = 0x11,0x22,0x33,0x44 -> BOOT bubble, then IF/ID shows (0x11,pc 0,valid), (0x22,pc 1), (0x33,pc 2) on consecutive edges.
- `stall_i` high for 3 cycles while IF/ID holds (0x22,pc 1) -> PC stays 2 and IF/ID is unchanged for 3 edges. 0x33 follows on the release edge.
- `redirect_i`=1 with target 0x40 at PC 5, `stall_i`=1 in the same cycle -> one bubble, then (mem[0x40],pc 0x40,valid).
- `halt_i` pulse -> `halted_o`=1 and bubbles continue indefinitely. Redirect to 0 -> RUN resumes from 0 and `halted_o` drops.
- PC forced via redirect to 0xFFFFFFFF -> next PC is 0 and both instructions are fetched valid.
- With `FETCH_PERF_CNT_EN` defined: 10 normal fetches, 2 stalls and 1 redirect -> `perf_fetched_o`=10, `perf_bubbles_o`=3. Asserting `rst_n` low mid-run -> both counters are 0 immediately.
